// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier, one step per clock, start/done handshake.
// Optional MULT_OVF_EN adds an ovf output (product not representable in N bits).
module seq_booth_multiplier #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
`ifdef MULT_OVF_EN
    ,
    output logic           ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [N:0]     acc;
    logic [N:0]     mcand;
    logic [N-1:0]   q;
    logic           q_m1;
    logic [CW-1:0]  cnt;

    logic [N:0]     sum;
    logic [N:0]     acc_n;
    logic [N-1:0]   q_n;
    logic [2*N-1:0] p_n;
    logic           last;
    logic           accept;

    assign last = (cnt == CW'(N - 1));

    // Accumulator is one bit wider than A so -2^(N-1) can be subtracted safely
    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_n = {sum[N], sum[N:1]};
        q_n   = {sum[0], q[N-1:1]};
        p_n   = {acc_n[N-1:0], q_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done  = 1'b1;
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            P     <= '0;
        end else if (accept) begin
            acc   <= '0;
            mcand <= {A[N-1], A};
            q     <= B;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc  <= acc_n;
            q    <= q_n;
            q_m1 <= q[0];
            cnt  <= cnt + CW'(1);
            if (last) begin
                P <= p_n;
            end
        end
    end

`ifdef MULT_OVF_EN
    logic [N:0] p_top;
    logic       ovf_n;

    // Representable in N bits only when the top N+1 bits are all sign copies
    assign p_top = p_n[2*N-1:N-1];
    assign ovf_n = !((&p_top) || !(|p_top));

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= ovf_n;
        end
    end
`endif

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed self-checking bench for seq_booth_multiplier at N=5.
// Covers latency, back-to-back issue, corner operands, mid-run reset, held start.
module tb_seq_booth_multiplier;

    localparam int N = 5;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;
`ifdef MULT_OVF_EN
    logic           ovf;
`endif

    int checks;
    int errors;

    seq_booth_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .P     (P)
`ifdef MULT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op (from IDLE or DONE), checks done timing and result.
    task automatic run_op(input string tag, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [2*N-1:0] exp_p,
                          input logic exp_ovf, input logic hold_start);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = hold_start;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i < N; i++) begin
            A = N'($urandom);
            B = N'($urandom);
            step();
            chk({tag, "_nodone"}, 32'(done), 32'd0);
        end
        A = N'($urandom);
        B = N'($urandom);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_P"}, 32'(P), 32'(exp_p));
`ifdef MULT_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) chk({tag, "_x"}, 32'd0, 32'd1);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_P", 32'(P), 32'd0);
`ifdef MULT_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        step();

        // -10*4 then 11*-3 issued in the DONE cycle
        run_op("m10x4", 5'b10110, 5'b00100, 10'b1111011000, 1'b1, 1'b0);
        run_op("11xm3", 5'b01011, 5'b11101, 10'b1111011111, 1'b1, 1'b0);
        step();
        chk("idle_ret", 32'(done), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("hold_P", 32'(P), 32'(10'b1111011111));

        run_op("m10xm11", 5'b10110, 5'b10101, 10'b0001101110, 1'b1, 1'b0);
        run_op("2x3", 5'b00010, 5'b00011, 10'b0000000110, 1'b0, 1'b0);
        run_op("m16xm16", 5'b10000, 5'b10000, 10'b0100000000, 1'b1, 1'b0);
        run_op("m16x1", 5'b10000, 5'b00001, 10'b1111110000, 1'b0, 1'b0);
        step();

        // Reset during the third RUN cycle
        A = 5'b00111;
        B = 5'b00111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_P", 32'(P), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < N + 1; i++) begin
            step();
            chk("mid_rst_nodone", 32'(done), 32'd0);
        end
        run_op("post_rst", 5'b00010, 5'b00011, 10'b0000000110, 1'b0, 1'b0);
        step();

        // start held high, operands toggling: only accept-edge values count
        run_op("hold_7x7", 5'b00111, 5'b00111, 10'b0000110001, 1'b1, 1'b1);
        run_op("hold_m5x3", 5'b11011, 5'b00011, 10'b1111110001, 1'b0, 1'b1);
        run_op("hold_15xm16", 5'b01111, 5'b10000, 10'b1100010000, 1'b1, 1'b1);
        start = 1'b0;
        step();
        chk("hold_end_done", 32'(done), 32'd0);
        chk("hold_end_P", 32'(P), 32'(10'b1100010000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
